// File: rtl/aes_output_buffer_if.sv
// aes_output_buffer_if: block capture from the AES pipeline and 32-bit word drain to the consumer
interface aes_output_buffer_if #(parameter int DEPTH = 4);
    logic [127:0]           i_data;
    logic                   i_data_done;
    logic                   o_full;
    logic [31:0]            o_word;
    logic                   o_word_valid;
    logic                   i_word_ready;
    logic                   o_word_last;
    logic [$clog2(DEPTH):0] o_count;
    logic                   i_clear;
    modport master (
        output i_data, i_data_done, i_word_ready, i_clear,
        input  o_full, o_word, o_word_valid, o_word_last, o_count
    );
    modport slave (
        input  i_data, i_data_done, i_word_ready, i_clear,
        output o_full, o_word, o_word_valid, o_word_last, o_count
    );
endinterface

// File: rtl/aes_output_buffer.sv
// aes_output_buffer: circular buffer of decrypted 128-bit blocks drained MS-word-first as 32-bit words
module aes_output_buffer #(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    aes_output_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [127:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    idx;
    logic          capture, xfer, pop;
    // o_full comes from registered count only, so the stall has no input-to-output path
    assign bus.o_full       = count == (AW+1)'(DEPTH);
    assign bus.o_word_valid = count != '0;
    assign bus.o_word_last  = bus.o_word_valid & (idx == 2'd3);
    assign bus.o_count      = count;
    assign bus.o_word       = mem[rd_ptr][{~idx, 5'd0} +: 32];
    assign capture          = bus.i_data_done & ~bus.o_full & ~bus.i_clear;
    assign xfer             = bus.o_word_valid & bus.i_word_ready & ~bus.i_clear;
    assign pop              = xfer & (idx == 2'd3);
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= bus.i_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            idx    <= '0;
        end else if (bus.i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            idx    <= '0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (xfer) idx <= idx + 2'd1;
            count <= count + (AW+1)'(capture) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_aes_output_buffer.sv
// tb_aes_output_buffer: randomized and directed checks of aes_output_buffer against a block-queue model
module tb_aes_output_buffer;
    localparam int DEPTH = 4;
    logic clk = 0;
    logic rst;
    aes_output_buffer_if #(.DEPTH(DEPTH)) bus ();
    aes_output_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [127:0] q[$];
    int           widx;
    bit           cap;
    int           n_assert = 0;
    int           n_fail = 0;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check();
        logic [127:0] b;
        chk("count", 128'(bus.o_count), 128'(q.size()));
        chk("full", 128'(bus.o_full), 128'(q.size() == DEPTH));
        chk("valid", 128'(bus.o_word_valid), 128'(q.size() != 0));
        chk("last", 128'(bus.o_word_last), 128'(q.size() != 0 && widx == 3));
        if (q.size() != 0) begin
            b = q[0];
            chk("word", 128'(bus.o_word), 128'(32'(b >> (32 * (3 - widx)))));
        end
    endtask

    // model advances on each rising edge using the inputs held across it
    task automatic step();
        bit c, x;
        @(posedge clk);
        cap = 0;
        if (rst || bus.i_clear) begin
            q.delete();
            widx = 0;
        end else begin
            c = bus.i_data_done && q.size() < DEPTH;
            x = q.size() != 0 && bus.i_word_ready;
            if (x) begin
                if (widx == 3) begin
                    void'(q.pop_front());
                    widx = 0;
                end else widx++;
            end
            if (c) q.push_back(bus.i_data);
            cap = c;
        end
        #1 check();
    endtask

    task automatic send_hold(logic [127:0] d, int max);
        int k = 0;
        bus.i_data = d;
        bus.i_data_done = 1;
        do begin
            step();
            k++;
        end while (!cap && k < max);
        chk("send_bound", 128'(cap), 128'(1));
        bus.i_data_done = 0;
    endtask

    task automatic drain(int max);
        int k = 0;
        bus.i_word_ready = 1;
        while (q.size() != 0 && k < max) begin
            step();
            k++;
        end
        chk("drain_bound", 128'(q.size()), 128'(0));
    endtask

    initial begin
        bit pat[4] = '{1, 0, 0, 1};
        logic [127:0] d;
        logic [31:0]  w;
        rst = 1;
        bus.i_data = '0;
        bus.i_data_done = 0;
        bus.i_word_ready = 0;
        bus.i_clear = 0;
        widx = 0;
        #1 check();
        step();
        step();
        rst = 0;

        bus.i_word_ready = 1;
        send_hold(128'h00112233445566778899aabbccddeeff, 1);
        chk("sb_w0", 128'(bus.o_word), 128'(32'h00112233));
        chk("sb_c1", 128'(bus.o_count), 128'(1));
        step();
        chk("sb_w1", 128'(bus.o_word), 128'(32'h44556677));
        step();
        chk("sb_w2", 128'(bus.o_word), 128'(32'h8899aabb));
        chk("sb_l2", 128'(bus.o_word_last), 128'(0));
        step();
        chk("sb_w3", 128'(bus.o_word), 128'(32'hccddeeff));
        chk("sb_l3", 128'(bus.o_word_last), 128'(1));
        step();
        chk("sb_c0", 128'(bus.o_count), 128'(0));

        bus.i_word_ready = 0;
        for (int i = 0; i < DEPTH; i++) send_hold(rnd128(), 1);
        chk("fill_full", 128'(bus.o_full), 128'(1));
        chk("fill_cnt", 128'(bus.o_count), 128'(4));
        bus.i_data = rnd128();
        bus.i_data_done = 1;
        repeat (6) begin
            step();
            chk("stall_cnt", 128'(bus.o_count), 128'(4));
        end
        bus.i_word_ready = 1;
        send_hold(bus.i_data, 20);
        drain(40);

        bus.i_word_ready = 0;
        send_hold(rnd128(), 1);
        for (int i = 0; i < 16; i++) begin
            w = bus.o_word;
            bus.i_word_ready = pat[i % 4];
            step();
            if (!pat[i % 4]) chk("bp_hold", 128'(bus.o_word), 128'(w));
        end
        drain(8);

        bus.i_word_ready = 1;
        for (int i = 0; i < 10; i++) begin
            send_hold(rnd128(), 10);
            repeat ($urandom_range(0, 5)) step();
        end
        drain(60);

        bus.i_word_ready = 0;
        send_hold(rnd128(), 1);
        send_hold(rnd128(), 1);
        bus.i_word_ready = 1;
        repeat (3) step();
        send_hold(rnd128(), 1);
        chk("cap_pop_cnt", 128'(bus.o_count), 128'(2));
        drain(20);

        bus.i_word_ready = 0;
        repeat (3) send_hold(rnd128(), 1);
        bus.i_word_ready = 1;
        repeat (2) step();
        bus.i_word_ready = 0;
        bus.i_clear = 1;
        step();
        bus.i_clear = 0;
        chk("clr_cnt", 128'(bus.o_count), 128'(0));
        chk("clr_valid", 128'(bus.o_word_valid), 128'(0));
        d = rnd128();
        send_hold(d, 1);
        chk("clr_idx", 128'(bus.o_word), 128'(d[127:96]));
        step();

        repeat (3) send_hold(rnd128(), 1);
        bus.i_data = rnd128();
        bus.i_data_done = 1;
        repeat (2) step();
        bus.i_clear = 1;
        step();
        bus.i_clear = 0;
        send_hold(bus.i_data, 2);
        chk("clr_stall_cnt", 128'(bus.o_count), 128'(1));
        drain(10);

        bus.i_word_ready = 0;
        repeat (DEPTH) send_hold(rnd128(), 1);
        bus.i_word_ready = 1;
        step();
        #2 rst = 1;
        #1;
        q.delete();
        widx = 0;
        check();
        chk("arst_full", 128'(bus.o_full), 128'(0));
        step();
        rst = 0;

        for (int i = 0; i < 400; i++) begin
            if (!bus.i_data_done || cap) begin
                bus.i_data_done = ($urandom % 3) == 0;
                bus.i_data = rnd128();
            end
            bus.i_word_ready = ($urandom % 4) != 0;
            bus.i_clear = ($urandom % 50) == 0;
            step();
        end
        bus.i_clear = 0;
        bus.i_data_done = 0;
        drain(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
